// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared motor-control types and constants
package motor_pkg;

  // 100 MHz system clock, 250 kbaud command link
  localparam int CLKS_PER_BIT_100M_250K = 400;

  // Command receiver states
  typedef enum logic [2:0] {
    IDLE_WAIT = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  // Two-out-of-three vote used for mid-bit sampling
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop synchronizer for asynchronous idle-high inputs
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two flops in series; reset to the idle level so no false edge appears at release
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_pwm_cmd_rx.sv
// rtl/uart_pwm_cmd_rx.sv - 8N1 receiver loading the PWM duty register
module uart_pwm_cmd_rx
  import motor_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_100M_250K,
  parameter logic [7:0] PWM_RESET    = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] PWM_Val,
  output logic       Byte_Valid,
  output logic       Frame_Err
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HM1  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_H    = CW'(HALF);
  localparam logic [CW-1:0] CNT_HP1  = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          samp_a;
  logic          samp_b;
  logic          rx_s;
  logic          vote;
  logic          decide;
  logic          wrap;

  rx_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RX),
    .q   (rx_s)
  );

  // Majority of the three mid-bit samples; the third sample is the live one
  always_comb begin
    vote   = maj3(samp_a, samp_b, rx_s);
    decide = (cnt == CNT_HP1);
    wrap   = (cnt == CNT_LAST);
  end

  // Frame FSM, bit timing, data shift and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE_WAIT;
      cnt        <= '0;
      bit_idx    <= 4'd0;
      shreg      <= 8'h00;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      PWM_Val    <= PWM_RESET;
      Byte_Valid <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      Byte_Valid <= 1'b0;
      Frame_Err  <= 1'b0;

      if (cnt == CNT_HM1) samp_a <= rx_s;
      if (cnt == CNT_H)   samp_b <= rx_s;

      case (state)
        // Require a full bit time of continuous idle before arming for a start edge
        IDLE_WAIT: begin
          if (!rx_s) begin
            cnt <= '0;
          end else if (wrap) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // The cycle that first sees the low line is count 0 of the start bit
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= CNT_ONE;
            bit_idx <= 4'd0;
          end else begin
            cnt <= '0;
          end
        end

        // A start bit that votes high at mid-bit was a glitch
        START: begin
          if (decide && vote) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (wrap) begin
            state   <= DATA;
            bit_idx <= 4'd1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Right shift so the first received bit ends up in bit 0
        DATA: begin
          if (decide) shreg <= {vote, shreg[7:1]};
          if (wrap) begin
            cnt <= '0;
            if (bit_idx == 4'd8) begin
              state   <= STOP;
              bit_idx <= 4'd9;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Accept at mid stop bit so a back-to-back start edge is not missed
        STOP: begin
          if (decide) begin
            cnt <= '0;
            if (vote) begin
              PWM_Val    <= shreg;
              Byte_Valid <= 1'b1;
              state      <= IDLE;
            end else begin
              Frame_Err <= 1'b1;
              state     <= IDLE_WAIT;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pwm_cmd_rx.sv
// tb/tb_uart_pwm_cmd_rx.sv - directed self-checking bench for uart_pwm_cmd_rx
module tb_uart_pwm_cmd_rx;

  localparam int CPB   = 400;
  localparam int HALF  = CPB / 2;
  // RX edge -> pulse visible: 2 sync cycles + t0 cycle + 9 bits + HALF + 1
  localparam int LAT   = 3 + 9 * CPB + HALF + 1;

  logic       CLK;
  logic       RST;
  logic       RX;
  logic [7:0] PWM_Val;
  logic       Byte_Valid;
  logic       Frame_Err;

  int cyc;
  int bv_cnt, fe_cnt, both_cnt;
  int bv_last_cyc, bv_prev_cyc, fe_last_cyc;
  int n_tests, n_fail;
  int start_cyc, first_start, base_bv, base_fe;
  logic [7:0] pwm_in_rst;

  uart_pwm_cmd_rx #(
    .CLKS_PER_BIT (CPB),
    .PWM_RESET    (8'h00)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX         (RX),
    .PWM_Val    (PWM_Val),
    .Byte_Valid (Byte_Valid),
    .Frame_Err  (Frame_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge
  always @(negedge CLK) begin
    if (Byte_Valid) begin
      bv_cnt      <= bv_cnt + 1;
      bv_prev_cyc <= bv_last_cyc;
      bv_last_cyc <= cyc;
    end
    if (Frame_Err) begin
      fe_cnt      <= fe_cnt + 1;
      fe_last_cyc <= cyc;
    end
    if (Byte_Valid && Frame_Err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_high(input int n);
    RX = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives one 10-bit frame, CPB cycles per bit; optional 1-cycle glitch or reset pulse in a bit
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int glitch_bit, input int rst_bit);
    logic b;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      b = (i == 0) ? 1'b0 : (i == 9) ? stop : data[i-1];
      RX = b;
      if (i == glitch_bit) begin
        repeat (HALF + 1) @(posedge CLK);
        #1; RX = ~b;
        @(posedge CLK);
        #1; RX = b;
        repeat (CPB - HALF - 2) @(posedge CLK);
        #1;
      end else if (i == rst_bit) begin
        repeat (HALF) @(posedge CLK);
        #1; RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1; pwm_in_rst = PWM_Val; RST = 1'b0;
        repeat (CPB - HALF - 4) @(posedge CLK);
        #1;
      end else begin
        repeat (CPB) @(posedge CLK);
        #1;
      end
    end
    RX = 1'b1;
  endtask

  initial begin
    cyc = 0; bv_cnt = 0; fe_cnt = 0; both_cnt = 0;
    bv_last_cyc = 0; bv_prev_cyc = 0; fe_last_cyc = 0;
    n_tests = 0; n_fail = 0;
    RST = 1'b1;
    RX  = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("rst_pwm", PWM_Val, 8'h00);
    check("rst_bv", Byte_Valid, 1'b0);
    check("rst_fe", Frame_Err, 1'b0);

    // Line held low after reset must not look like a start bit
    RST = 1'b0;
    repeat (2 * CPB) @(posedge CLK);
    #1;
    check("low_bv_cnt", bv_cnt, 0);
    check("low_fe_cnt", fe_cnt, 0);
    check("low_pwm", PWM_Val, 8'h00);

    idle_high(CPB + 20);

    // 0x0F: bits 0,1,1,1,1,0,0,0,0,1
    send_frame(8'h0F, 1'b1, -1, -1);
    check("f0f_cnt", bv_cnt, 1);
    check("f0f_time", bv_last_cyc, start_cyc + LAT);
    check("f0f_pwm", PWM_Val, 8'h0F);

    // Back-to-back frames
    idle_high(30);
    send_frame(8'hA5, 1'b1, -1, -1);
    first_start = start_cyc;
    send_frame(8'h3C, 1'b1, -1, -1);
    check("b2b_cnt", bv_cnt, 3);
    check("b2b_first", bv_prev_cyc, first_start + LAT);
    check("b2b_gap", bv_last_cyc - bv_prev_cyc, 10 * CPB);
    check("b2b_pwm", PWM_Val, 8'h3C);

    // Framing error: 0x55 with stop bit low
    idle_high(30);
    base_bv = bv_cnt;
    send_frame(8'h55, 1'b0, -1, -1);
    check("fe_cnt", fe_cnt, 1);
    check("fe_time", fe_last_cyc, start_cyc + LAT);
    check("fe_no_bv", bv_cnt, base_bv);
    check("fe_pwm", PWM_Val, 8'h3C);

    // Too little idle after the error: 0x00 frame must be ignored
    idle_high(100);
    send_frame(8'h00, 1'b1, -1, -1);
    check("early_bv", bv_cnt, base_bv);
    check("early_fe", fe_cnt, 1);

    // Idle has now been long enough
    idle_high(50);
    send_frame(8'h81, 1'b1, -1, -1);
    check("rearm_bv", bv_cnt, base_bv + 1);
    check("rearm_pwm", PWM_Val, 8'h81);

    // 50-cycle low glitch on idle line
    idle_high(100);
    base_bv = bv_cnt;
    RX = 1'b0;
    repeat (50) @(posedge CLK);
    #1;
    idle_high(2 * CPB);
    check("glitch_bv", bv_cnt, base_bv);
    check("glitch_fe", fe_cnt, 1);

    // Single-cycle glitch mid data bit 3
    send_frame(8'hC3, 1'b1, 3, -1);
    check("vote_cnt", bv_cnt, base_bv + 1);
    check("vote_pwm", PWM_Val, 8'hC3);

    // Reset during data bit 4 of a 0xF0 frame
    idle_high(50);
    base_bv = bv_cnt;
    base_fe = fe_cnt;
    send_frame(8'hF0, 1'b1, -1, 4);
    check("mrst_pwm", pwm_in_rst, 8'h00);
    idle_high(CPB + 50);
    check("mrst_bv", bv_cnt, base_bv);
    check("mrst_fe", fe_cnt, base_fe);

    send_frame(8'h96, 1'b1, -1, -1);
    check("post_rst_cnt", bv_cnt, base_bv + 1);
    check("post_rst_pwm", PWM_Val, 8'h96);

    idle_high(20);
    check("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
